// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sequencer: walks every input vector of a small combinational block,
// samples its output after a settle time and compares the result with an expected table.
// Optional macro TRUTH_TABLE_SEQUENCER_STOP_ON_FAIL_EN ends the run on the first mismatching vector.
module truth_table_sequencer #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_count,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic                   first_fail_valid,
    output logic [(2**N_IN)-1:0]   captured
);

    localparam int T  = 2 ** N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;
    localparam logic [N_IN:0]   MC_ONE   = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [T-1:0]    exp_q, exp_d;
    logic [T-1:0]    captured_q, captured_d;
    logic [N_IN:0]   mc_q, mc_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            ffv_q, ffv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            miss;
    logic            stop_early;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            captured_q <= '0;
            mc_q       <= '0;
            ffi_q      <= '0;
            ffv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            captured_q <= captured_d;
            mc_q       <= mc_d;
            ffi_q      <= ffi_d;
            ffv_q      <= ffv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        captured_d = captured_q;
        mc_d       = mc_q;
        ffi_d      = ffi_q;
        ffv_d      = ffv_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        miss       = dut_out != exp_q[idx_q];
`ifdef TRUTH_TABLE_SEQUENCER_STOP_ON_FAIL_EN
        stop_early = miss && !ffv_q;
`else
        stop_early = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // abort outranks a coincident start
                if (start && !abort) begin
                    exp_d      = expected;
                    captured_d = '0;
                    mc_d       = '0;
                    ffi_d      = '0;
                    ffv_d      = 1'b0;
                    pass_d     = 1'b0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SAMPLE;
                    end
                end
            end

            S_SAMPLE: begin
                // the sample is recorded even when the run is being aborted
                captured_d[idx_q] = dut_out;
                if (miss) begin
                    mc_d = mc_q + MC_ONE;
                    if (!ffv_q) begin
                        ffi_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end

                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (idx_q == IDX_LAST || stop_early) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mc_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dut_in           = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_count   = mc_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;
    assign captured         = captured_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: directed and random runs against a table-level model
// of the captured truth table, mismatch statistics and run timing.
module tb_truth_table_sequencer;

    localparam int N_IN    = 4;
    localparam int S       = 1;
    localparam int T       = 1 << N_IN;
    localparam int VEC_CYC = S + 1;

    logic            clk      = 1'b0;
    logic            rst      = 1'b0;
    logic            start    = 1'b0;
    logic            abort    = 1'b0;
    logic [T-1:0]    expected = '0;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_count;
    logic [N_IN-1:0] first_fail_idx;
    logic            first_fail_valid;
    logic [T-1:0]    captured;

    logic [T-1:0]    cut_tbl  = '0;
    logic [T-1:0]    plan_tbl = '0;
    int              n_total  = 0;
    int              n_bad    = 0;

    typedef struct {
        logic [T-1:0] cap;
        int           mism;
        int           first;
        logic         valid;
        logic         pass;
        int           done_edge;
    } result_t;

    // circuit under test: a lookup of the current vector
    assign dut_out = cut_tbl[dut_in];

    always #5 clk = ~clk;

    truth_table_sequencer #(.N_IN(N_IN), .SETTLE_CYCLES(S)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .expected         (expected),
        .dut_in           (dut_in),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_count   (mismatch_count),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid),
        .captured         (captured)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_plan(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (!a && c && !d) || (a && !c && !d) || (b && c && !d);
    endfunction

    function automatic result_t predict(input logic [T-1:0] tbl, input logic [T-1:0] exp_t);
        result_t      r;
        logic [T-1:0] diff;
        diff        = tbl ^ exp_t;
        r.cap       = tbl;
        r.mism      = $countones(diff);
        r.valid     = (diff != '0);
        r.first     = 0;
        for (int i = T - 1; i >= 0; i--) if (diff[i]) r.first = i;
        r.done_edge = T * VEC_CYC;
`ifdef TRUTH_TABLE_SEQUENCER_STOP_ON_FAIL_EN
        if (r.valid) begin
            r.mism      = 1;
            r.done_edge = (r.first + 1) * VEC_CYC;
            for (int i = 0; i < T; i++) if (i > r.first) r.cap[i] = 1'b0;
        end
`endif
        r.pass = (r.mism == 0);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".dut_in"}, 32'(dut_in), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".pass"}, 32'(pass), 0);
        check({tag, ".mism"}, 32'(mismatch_count), 0);
        check({tag, ".ffi"}, 32'(first_fail_idx), 0);
        check({tag, ".ffv"}, 32'(first_fail_valid), 0);
        check({tag, ".cap"}, 32'(captured), 0);
    endtask

    task automatic full_run(input string tag, input logic [T-1:0] exp_t, input int restart_edge);
        result_t r;
        int      e;
        int      done_edge;
        int      seq_bad;
        r = predict(cut_tbl, exp_t);
        @(negedge clk);
        expected = exp_t;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        expected = ~exp_t;
        e         = 0;
        done_edge = -1;
        seq_bad   = 0;
        while (done_edge < 0 && e < 4 * T * VEC_CYC) begin
            if (e + 1 == restart_edge) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            e++;
            @(negedge clk);
            if (done) done_edge = e;
            else if (!busy || dut_in !== N_IN'(e / VEC_CYC)) seq_bad++;
        end
        check({tag, ".done_edge"}, done_edge, r.done_edge);
        check({tag, ".seq_bad"}, seq_bad, 0);
        check({tag, ".busy_at_done"}, 32'(busy), 0);
        check({tag, ".cap"}, 32'(captured), 32'(r.cap));
        check({tag, ".mism"}, 32'(mismatch_count), r.mism);
        check({tag, ".ffv"}, 32'(first_fail_valid), 32'(r.valid));
        check({tag, ".ffi"}, 32'(first_fail_idx), r.first);
        check({tag, ".pass"}, 32'(pass), 32'(r.pass));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 0);
        repeat (3) @(negedge clk);
        check({tag, ".hold_cap"}, 32'(captured), 32'(r.cap));
        check({tag, ".hold_mism"}, 32'(mismatch_count), r.mism);
        check({tag, ".hold_pass"}, 32'(pass), 32'(r.pass));
    endtask

    task automatic abort_run(input string tag, input logic [T-1:0] exp_t, input int abort_edge);
        int           nrec;
        int           first;
        int           seen_done;
        logic [T-1:0] m;
        logic [T-1:0] diff;
        nrec = abort_edge / VEC_CYC;
        m    = '0;
        for (int i = 0; i < nrec; i++) m[i] = 1'b1;
`ifdef TRUTH_TABLE_SEQUENCER_STOP_ON_FAIL_EN
        exp_t = (exp_t & ~m) | (cut_tbl & m);
`endif
        diff  = (cut_tbl ^ exp_t) & m;
        first = 0;
        for (int i = T - 1; i >= 0; i--) if (diff[i]) first = i;
        @(negedge clk);
        expected = exp_t;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        expected  = ~exp_t;
        seen_done = 0;
        for (int e = 1; e <= abort_edge; e++) begin
            if (e == abort_edge) abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            @(negedge clk);
            if (done) seen_done++;
        end
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".pass"}, 32'(pass), 0);
        check({tag, ".cap"}, 32'(captured), 32'(cut_tbl & m));
        check({tag, ".mism"}, 32'(mismatch_count), $countones(diff));
        check({tag, ".ffv"}, 32'(first_fail_valid), 32'(diff != '0));
        check({tag, ".ffi"}, 32'(first_fail_idx), first);
        check({tag, ".dut_in"}, 32'(dut_in), (abort_edge - 1) / VEC_CYC);
        repeat (2 * VEC_CYC + 2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check({tag, ".no_done"}, seen_done, 0);
        check({tag, ".dut_in_held"}, 32'(dut_in), (abort_edge - 1) / VEC_CYC);
        check({tag, ".idle"}, 32'(busy), 0);
    endtask

    initial begin
        logic [T-1:0] exp_r;
        logic [T-1:0] one_hot;
        int           mode;

        for (int i = 0; i < T; i++) plan_tbl[i] = f_plan(4'(i));
        cut_tbl = plan_tbl;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        check("plan_table", 32'(plan_tbl), 32'h5144);
        full_run("match", 16'h5144, 0);
        full_run("one_off", 16'h5145, 0);
        full_run("all_off", 16'hAEBB, 0);
        full_run("restart_ignored", 16'h5144, 10);
        abort_run("abort_settle", 16'h5144, 5 * VEC_CYC + 1);
        abort_run("abort_sample", 16'hA5A5, 6 * VEC_CYC);

        // coincident start and abort in IDLE must not start a run
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort.busy", 32'(busy), 0);
        check("start_abort.dut_in", 32'(dut_in), 5);

        // asynchronous reset in the middle of a run (vector 7 applied)
        @(negedge clk);
        expected = 16'h5144;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7 * VEC_CYC) @(posedge clk);
        @(negedge clk);
        check("pre_rst.dut_in", 32'(dut_in), 7);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        full_run("after_rst", 16'h5144, 0);

        for (int k = 0; k < 6; k++) begin
            cut_tbl = T'($urandom);
            mode    = $urandom_range(0, 2);
            one_hot = '0;
            one_hot[$urandom_range(0, T - 1)] = 1'b1;
            case (mode)
                0:       exp_r = cut_tbl;
                1:       exp_r = cut_tbl ^ one_hot;
                default: exp_r = T'($urandom);
            endcase
            full_run($sformatf("rnd%0d", k), exp_r, 0);
        end

        cut_tbl = T'($urandom);
        abort_run("rnd_abort_sample", T'($urandom), VEC_CYC * $urandom_range(1, T - 1));
        cut_tbl = T'($urandom);
        abort_run("rnd_abort_settle", T'($urandom), VEC_CYC * $urandom_range(0, T - 1) + 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
